// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   master: drives start/op/a/b, observes results, flags, busy and done.
//   slave : the ALU itself.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             dbz;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, result_hi, carry, zero, ovf, dbz, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, result_hi, carry, zero, ovf, dbz, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus.start/op/a/b       : request, sampled when busy=0.
//   bus.result/result_hi   : low result / product high word or remainder.
//   bus.carry/zero/ovf/dbz : status flags, registered with the result.
//   bus.busy               : iterative mul/div in progress.
//   bus.done               : one-cycle pulse when outputs are updated.
// Single-cycle ops complete on the sampling edge; mul/div iterate one bit
// per edge for WIDTH edges.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
    OP_SHR = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // hi/lo: {accumulator, multiplier} for mul, {remainder, dividend} for div.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             dbz_q, dbz_d, done_q, done_d;

  logic [WIDTH:0]   add_r, sub_r, mul_sum, div_trial, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    add_r = {1'b0, bus.a} + {1'b0, bus.b};
    sub_r = {1'b0, bus.a} - {1'b0, bus.b};

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole {carry, hi, lo} right.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder.
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_trial - {1'b0, opb_q}) : div_trial;

    if (is_div_q) begin
      step_hi = div_rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          result_hi_d = '0;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          unique case (op_e'(bus.op))
            OP_ADD: begin
              result_d = add_r[WIDTH-1:0];
              carry_d  = add_r[WIDTH];
              ovf_d    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
              result_d = sub_r[WIDTH-1:0];
              carry_d  = sub_r[WIDTH];
              ovf_d    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHR: begin
              result_d = bus.a >> 1;
              carry_d  = bus.a[0];
            end
            OP_AND: result_d = bus.a & bus.b;
            OP_OR:  result_d = bus.a | bus.b;
            OP_XOR: result_d = bus.a ^ bus.b;
            OP_MUL, OP_DIV: begin
              if (op_e'(bus.op) == OP_DIV && bus.b == '0) begin
                result_d    = '1;
                result_hi_d = bus.a;
                dbz_d       = 1'b1;
              end else begin
                // Iterative path: previous outputs stay untouched until done.
                result_hi_d = result_hi_q;
                carry_d     = carry_q;
                ovf_d       = ovf_q;
                dbz_d       = dbz_q;
                done_d      = 1'b0;
                is_div_d    = (op_e'(bus.op) == OP_DIV);
                hi_d        = '0;
                lo_d        = is_div_d ? bus.a : bus.b;
                opb_d       = is_div_d ? bus.b : bus.a;
                cnt_d       = CW'(WIDTH);
                state_d     = CALC;
              end
            end
            default: ;
          endcase
          if (done_d) zero_d = (result_d == '0);
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d    = step_lo;
          result_hi_d = step_hi;
          carry_d     = !is_div_q && (step_hi != '0);
          zero_d      = (step_lo == '0);
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;
  assign bus.busy      = (state_q == CALC);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011,
                         SHR = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8 ();
  alu_seq_if #(.WIDTH(16)) bus16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen (or after the bound expires).
  task automatic wait8(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 64 && bus8.done !== 1'b1; i++) begin
      if (bus8.busy === 1'b1) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic wait16(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 64 && bus16.done !== 1'b1; i++) begin
      if (bus16.busy === 1'b1) busy_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bn;
    int extra_done;
    bus8.start = 1'b0;  bus8.op = '0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;

    #12;
    chk("rst_result", bus8.result, 0);
    chk("rst_hi", bus8.result_hi, 0);
    chk("rst_flags", {bus8.carry, bus8.zero, bus8.ovf, bus8.dbz, bus8.busy, bus8.done}, 0);
    @(negedge clk) rst_n = 1'b1;

    // add 200+100 = 300 -> 44 with carry
    issue8(ADD, 8'd200, 8'd100);
    chk("add_done", bus8.done, 1);
    chk("add_result", bus8.result, 44);
    chk("add_carry", bus8.carry, 1);
    chk("add_ovf", bus8.ovf, 0);
    chk("add_busy", bus8.busy, 0);
    @(negedge clk);
    chk("add_done_pulse", bus8.done, 0);

    issue8(ADD, 8'd127, 8'd1);
    chk("add_ovf_result", bus8.result, 128);
    chk("add_ovf_flag", bus8.ovf, 1);
    chk("add_ovf_carry", bus8.carry, 0);

    issue8(SUB, 8'd5, 8'd10);
    chk("sub_result", bus8.result, 251);
    chk("sub_borrow", bus8.carry, 1);
    chk("sub_ovf", bus8.ovf, 0);

    issue8(SUB, 8'd10, 8'd10);
    chk("sub0_result", bus8.result, 0);
    chk("sub0_zero", bus8.zero, 1);
    chk("sub0_carry", bus8.carry, 0);

    // mul 200*3 = 600 = 0x258
    issue8(MUL, 8'd200, 8'd3);
    wait8(bn);
    chk("mul_busy_cycles", bn, 8);
    chk("mul_done", bus8.done, 1);
    chk("mul_done_busy", bus8.busy, 0);
    chk("mul_result", bus8.result, 8'h58);
    chk("mul_hi", bus8.result_hi, 8'h02);
    chk("mul_carry", bus8.carry, 1);
    chk("mul_zero", bus8.zero, 0);

    // start while busy is ignored
    issue8(MUL, 8'd200, 8'd3);
    bus8.start = 1'b1; bus8.op = ADD; bus8.a = 8'd1; bus8.b = 8'd1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(bn);
    chk("ign_done", bus8.done, 1);
    chk("ign_result", bus8.result, 8'h58);
    @(negedge clk);
    chk("ign_no_extra_done", bus8.done, 0);
    chk("ign_hold", bus8.result, 8'h58);

    // back-to-back: shr issued in the cycle the mul reports done
    issue8(MUL, 8'd200, 8'd3);
    wait8(bn);
    chk("b2b_mul_done", bus8.done, 1);
    bus8.start = 1'b1; bus8.op = SHR; bus8.a = 8'h81; bus8.b = 8'h00;
    @(negedge clk);
    bus8.start = 1'b0;
    chk("b2b_shr_done", bus8.done, 1);
    chk("b2b_shr_result", bus8.result, 8'h40);
    chk("b2b_shr_carry", bus8.carry, 1);
    chk("b2b_shr_hi", bus8.result_hi, 0);
    @(negedge clk);
    chk("b2b_done_pulse", bus8.done, 0);

    // div 200/7 = 28 r 4
    issue8(DIV, 8'd200, 8'd7);
    wait8(bn);
    chk("div_busy_cycles", bn, 8);
    chk("div_done", bus8.done, 1);
    chk("div_quot", bus8.result, 28);
    chk("div_rem", bus8.result_hi, 4);
    chk("div_carry", bus8.carry, 0);

    // divide by zero
    issue8(DIV, 8'd9, 8'd0);
    chk("dbz_done", bus8.done, 1);
    chk("dbz_busy", bus8.busy, 0);
    chk("dbz_result", bus8.result, 8'hFF);
    chk("dbz_hi", bus8.result_hi, 9);
    chk("dbz_flag", bus8.dbz, 1);

    issue8(ADD, 8'd1, 8'd1);
    chk("dbz_clear", bus8.dbz, 0);
    chk("dbz_clear_result", bus8.result, 2);

    // reset in the middle of a divide
    issue8(DIV, 8'd200, 8'd7);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_result", bus8.result, 0);
    chk("mrst_hi", bus8.result_hi, 0);
    chk("mrst_flags", {bus8.carry, bus8.zero, bus8.ovf, bus8.dbz, bus8.busy, bus8.done}, 0);
    @(negedge clk) rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) extra_done++;
    end
    chk("mrst_no_done", extra_done, 0);
    issue8(ADD, 8'd3, 8'd4);
    chk("mrst_add_done", bus8.done, 1);
    chk("mrst_add_result", bus8.result, 7);

    // WIDTH=16
    issue16(MUL, 16'd60000, 16'd2);
    wait16(bn);
    chk("w16_mul_busy_cycles", bn, 16);
    chk("w16_mul_done", bus16.done, 1);
    chk("w16_mul_result", bus16.result, 16'hD4C0);
    chk("w16_mul_hi", bus16.result_hi, 16'h0001);
    chk("w16_mul_carry", bus16.carry, 1);

    issue16(DIV, 16'd60000, 16'd7);
    wait16(bn);
    chk("w16_div_quot", bus16.result, 8571);
    chk("w16_div_rem", bus16.result_hi, 3);

    issue16(ADD, 16'hFFFF, 16'h0001);
    chk("w16_add_result", bus16.result, 0);
    chk("w16_add_flags", {bus16.carry, bus16.zero, bus16.ovf}, 3'b110);

    issue16(SUB, 16'h8000, 16'h0001);
    chk("w16_sub_result", bus16.result, 16'h7FFF);
    chk("w16_sub_flags", {bus16.carry, bus16.zero, bus16.ovf}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
